// File: rtl/prbs_arb_pkg.sv
// Shared types and default sizing for the PRBS requester arbiter.
//   - arb_state_e : sequencer FSM states
//   - arb_tag_t   : tag carried alongside each generator request
package prbs_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned LEN_W_DEF   = 8;
  localparam int unsigned GEN_LAT_DEF = 1;
  localparam int unsigned ID_W_DEF    = 2;

  // Tag id is sized for the largest supported requester count (8)
  localparam int unsigned TAG_ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } arb_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req      : request vector
//   i_last_gnt : index granted last; search starts one above it
//   o_gnt      : one-hot grant (zero when no request)
//   o_idx      : index of the granted request
//   o_any      : at least one request present
module rr_pick
  import prbs_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = ID_W_DEF
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_gnt,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [NUM_REQ-1:0] w_gnt;

  // First set request walking upward from last_gnt+1, wrapping
  always_comb begin
    w_cand = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((32'(i_last_gnt) + k) % NUM_REQ);
      if (!w_any && i_req[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_any) w_gnt[w_idx] = 1'b1;
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_any = w_any;

endmodule

// File: rtl/prbs_req_arb.sv
// Round-robin sequencer sharing one 128-bit PRBS generator between requesters.
//   ck, rst_n            : clock, async active-low reset
//   req_vld/req_len      : per-requester burst request and length-1
//   req_rdy              : accept pulse (same cycle as grant)
//   hold                 : pauses issue to the generator
//   gen_req              : one generator word per asserted cycle
//   gen_vld/lower/upper  : generator result
//   rsp_vld/last/lower/upper : registered response steered to the owner
//   busy                 : burst active, tags in flight or response pending
//   err                  : sticky generator-valid vs tag mismatch
module prbs_req_arb
  import prbs_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned GEN_LAT = GEN_LAT_DEF,
  parameter int unsigned ID_W    = ID_W_DEF
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic                     hold,
  output logic                     gen_req,
  input  logic                     gen_vld,
  input  logic [63:0]              gen_lower,
  input  logic [63:0]              gen_upper,
  output logic [NUM_REQ-1:0]       rsp_vld,
  output logic                     rsp_last,
  output logic [63:0]              rsp_lower,
  output logic [63:0]              rsp_upper,
  output logic                     busy,
  output logic                     err
);

  arb_state_e         r_state, w_state_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt;
  logic [LEN_W-1:0]   r_rem, w_rem_nxt;
  logic [ID_W-1:0]    r_last_gnt, w_last_gnt_nxt;
  arb_tag_t           r_tag [GEN_LAT];
  arb_tag_t           w_push;
  arb_tag_t           w_tag_out;
  logic [NUM_REQ-1:0] r_rsp_vld, w_rsp_vld_nxt;
  logic               r_rsp_last;
  logic [63:0]        r_rsp_lower, r_rsp_upper;
  logic               r_err;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [ID_W-1:0]    w_pick_idx;
  logic               w_pick_any;
  logic [LEN_W-1:0]   w_len_sel;
  logic [NUM_REQ-1:0] w_rdy;
  logic               w_issue;
  logic               w_take;
  logic               w_tag_busy;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req      (req_vld),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_pick_gnt),
    .o_idx      (w_pick_idx),
    .o_any      (w_pick_any)
  );

  // Length field of the requester being picked
  always_comb begin
    w_len_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(w_pick_idx) == i) w_len_sel = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Sequencer next-state; grant is gated by rst_n so req_rdy stays low in reset
  always_comb begin
    w_state_nxt    = r_state;
    w_id_nxt       = r_id;
    w_rem_nxt      = r_rem;
    w_last_gnt_nxt = r_last_gnt;
    w_rdy          = '0;
    w_issue        = 1'b0;
    w_push         = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_any && rst_n) begin
          w_rdy          = w_pick_gnt;
          w_id_nxt       = w_pick_idx;
          w_rem_nxt      = w_len_sel;
          w_last_gnt_nxt = w_pick_idx;
          w_state_nxt    = BURST;
        end
      end
      BURST: begin
        if (!hold) begin
          w_issue      = 1'b1;
          w_push.valid = 1'b1;
          w_push.id    = TAG_ID_W'(r_id);
          w_push.last  = (r_rem == '0);
          if (r_rem == '0) w_state_nxt = IDLE;
          else             w_rem_nxt   = r_rem - LEN_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_rem      <= '0;
      r_last_gnt <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_id       <= w_id_nxt;
      r_rem      <= w_rem_nxt;
      r_last_gnt <= w_last_gnt_nxt;
    end
  end

  // Tag pipe mirrors generator latency; bubbles on non-issue cycles
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < GEN_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= w_push;
      for (int unsigned s = 1; s < GEN_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_tag_out = r_tag[GEN_LAT-1];
  assign w_take    = gen_vld && w_tag_out.valid;

  always_comb begin
    w_rsp_vld_nxt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_rsp_vld_nxt[i] = w_take && (32'(w_tag_out.id) == i);
    end
  end

  // Registered response; data holds between words
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld   <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_lower <= '0;
      r_rsp_upper <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_vld  <= w_rsp_vld_nxt;
      r_rsp_last <= w_take && w_tag_out.last;
      if (w_take) begin
        r_rsp_lower <= gen_lower;
        r_rsp_upper <= gen_upper;
      end
      if (gen_vld != w_tag_out.valid) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_tag_busy = 1'b0;
    for (int unsigned s = 0; s < GEN_LAT; s++) w_tag_busy = w_tag_busy | r_tag[s].valid;
  end

  assign req_rdy   = w_rdy;
  assign gen_req   = w_issue;
  assign rsp_vld   = r_rsp_vld;
  assign rsp_last  = r_rsp_last;
  assign rsp_lower = r_rsp_lower;
  assign rsp_upper = r_rsp_upper;
  assign err       = r_err;
  assign busy      = (r_state == BURST) || w_tag_busy || (|r_rsp_vld);

endmodule

// File: doc/prbs_req_arb.md
Name: prbs_req_arb

Overview:
- Round-robin arbiter and sequencer that shares one 128-bit PRBS generator between NUM_REQ requesters.
- Each requester asks for a burst of words. The block grants one requester at a time and drives the generator request line for the burst length.
- Generator results are tagged through a latency-matched pipeline and steered back to the granted requester with a last-word marker.
- Sits between the per-lane vadd test engines and the single shared PRBS generator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 8, burst length field width; burst length = req_len + 1 (1..2^LEN_W words).
- GEN_LAT, 1, generator latency in cycles from request to valid (1..4).
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- ck  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester burst request, held until accepted
- req_len  in  NUM_REQ*LEN_W  per-requester burst length minus one; slice i belongs to requester i
- req_rdy  out  NUM_REQ  one-cycle accept pulse, at most one bit set
- hold  in  1  pauses issue to the generator, for downstream throttling
- gen_req  out  1  request to the generator, one word per asserted cycle
- gen_vld  in  1  generator result valid
- gen_lower  in  64  generator result bits 63:0
- gen_upper  in  64  generator result bits 127:64
- rsp_vld  out  NUM_REQ  per-requester response valid, one-hot or zero
- rsp_last  out  1  final word of the burst, qualified by any rsp_vld bit
- rsp_lower  out  64  response data bits 63:0
- rsp_upper  out  64  response data bits 127:64
- busy  out  1  burst in progress or tags in flight
- err  out  1  sticky tag/valid mismatch flag

Behaviour:
- Reset is asynchronous and active-low, applied on rst_n low:
  - All outputs are 0. FSM goes to IDLE, tag pipe is cleared, err is cleared.
  - The round-robin pointer is set so requester 0 has the highest priority.
- Reset mid-burst abandons the burst. No further rsp_vld is produced, even if gen_vld arrives later.
- FSM states are IDLE and BURST.
- IDLE:
  - If any req_vld is set, pick the first set bit searching from (last_grant+1) mod NUM_REQ.
  - Pulse req_rdy[sel] in this same cycle.
  - Latch id and remaining = req_len[sel], update last_grant, go to BURST.
  - gen_req stays 0 in IDLE.
- BURST:
  - gen_req = !hold. This is combinational from state and hold.
  - On each issue cycle, push a tag {valid=1, id, last=(remaining==0)} into the tag pipe.
  - If remaining==0, return to IDLE; otherwise decrement remaining.
  - While hold=1, nothing is issued and the state is unchanged.
- Between bursts there is always at least one cycle with gen_req=0 (the IDLE cycle).
- Tag pipe:
  - GEN_LAT stages, shifted every cycle.
  - A bubble tag (valid=0) is inserted on non-issue cycles.
- Response stage is registered:
  - When gen_vld=1 and the tag output is valid: next cycle rsp_vld[tag.id]=1, rsp_last=tag.last, and rsp_lower/rsp_upper capture gen_lower/gen_upper.
  - Otherwise rsp_vld=0 and rsp_last=0. Data holds its last value.
- Latency: the first word's rsp_vld appears GEN_LAT+1 cycles after its gen_req cycle. Words stay in order with no loss.
- err:
  - Set when gen_vld differs from tag-output valid in any cycle.
  - Cleared only by reset. The response is suppressed in a mismatch cycle.
- busy = (state==BURST) OR any valid tag in the pipe OR a pending registered response.
- req_vld deasserting before its grant is legal; that requester is simply not chosen.
- req_len is sampled only in the grant cycle.
- Maximum length: req_len = 2^LEN_W-1 gives 2^LEN_W words. The counter must not wrap early.

Decomposition:
- Shared package prbs_arb_pkg holds:
  - the tag struct {valid, id[ID_W], last};
  - FSM state enum {IDLE, BURST};
  - default constants NUM_REQ, LEN_W, GEN_LAT.
- Sub-module rr_pick: combinational round-robin picker with inputs req vector and last_grant, outputs one-hot grant plus index. It is reusable by other arbiters.

Test Plan:
- Reset then requester 0 asserts req_len=3, generator attached:
  - req_rdy[0] pulses once; gen_req is high for 4 cycles.
  - rsp_vld[0] is high for 4 cycles starting 2 cycles after the first gen_req.
  - First word is rsp_lower=64'hFEDCBA9876543210, rsp_upper=64'h0123456789ABCDEF; rsp_last is on the 4th word.
- All 4 requesters assert req_len=0 continuously:
  - grants go 0,1,2,3,0 with one idle cycle between each;
  - each rsp_vld is one-hot with rsp_last=1.
- Requester 2 has req_len=2 and hold toggles 1,0,1,0 during BURST:
  - exactly 3 gen_req cycles occur, only where hold=0;
  - 3 in-order responses follow, the last one with rsp_last.
- req_len=255 (LEN_W=8):
  - exactly 256 gen_req cycles occur and 256 rsp_vld cycles, with a single rsp_last;
  - busy deasserts GEN_LAT+2 cycles after the last issue.
- rst_n pulsed low mid-burst (after 2 of 5 words):
  - all outputs go 0 immediately and no rsp_vld appears after release;
  - the next grant goes to requester 0.
- Force gen_vld=1 with no tag in flight:
  - err=1 from the next cycle and stays set; rsp_vld stays 0.
